// File: rtl/if_id_reg_if.sv
// Fetch/decode boundary bundle: fetch-side inputs, decode-side outputs and
// the performance counters of the IF/ID pipeline register.
interface if_id_reg_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      F_PC;
  logic [31:0]      F_instr;
  logic             stall;
  logic             flush;
  logic             freezePC;
  logic [31:0]      D_PC;
  logic [31:0]      D_PC8;
  logic [31:0]      D_instr;
  logic             D_valid;
  logic             D_adel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] issue_cnt;

  // Fetch stage and hazard unit side.
  modport master (
    output F_PC, F_instr, stall, flush,
    input  freezePC, D_PC, D_PC8, D_instr, D_valid, D_adel,
           stall_cnt, flush_cnt, issue_cnt
  );

  // Pipeline register side.
  modport slave (
    input  F_PC, F_instr, stall, flush,
    output freezePC, D_PC, D_PC8, D_instr, D_valid, D_adel,
           stall_cnt, flush_cnt, issue_cnt
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush bubbles, misaligned-PC
// flagging and saturating stall/flush/issue counters.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input logic        clk,
  input logic        reset,
  if_id_reg_if.slave bus
);

  logic [31:0]      pc_q;
  logic [31:0]      pc8_q;
  logic [31:0]      instr_q;
  logic             valid_q;
  logic             adel_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic             misaligned;

  // Fetch freezes in the same cycle decode holds, so no register here.
  assign bus.freezePC = bus.stall;
  assign misaligned   = (bus.F_PC[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      pc8_q       <= RESET_PC + 32'd8;
      instr_q     <= 32'h0;
      valid_q     <= 1'b0;
      adel_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else if (bus.stall) begin
      if (stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end else if (bus.flush) begin
      pc_q    <= bus.F_PC;
      pc8_q   <= bus.F_PC + 32'd8;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
      if (flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end else begin
      pc_q  <= bus.F_PC;
      pc8_q <= bus.F_PC + 32'd8;
      if (misaligned) begin
        instr_q <= 32'h0;
        valid_q <= 1'b0;
        adel_q  <= 1'b1;
      end else begin
        instr_q <= bus.F_instr;
        valid_q <= 1'b1;
        adel_q  <= 1'b0;
        if (issue_cnt_q != '1)
          issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  assign bus.D_PC      = pc_q;
  assign bus.D_PC8     = pc8_q;
  assign bus.D_instr   = instr_q;
  assign bus.D_valid   = valid_q;
  assign bus.D_adel    = adel_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch stage (PC generator plus instruction memory) and the decode stage.
- Captures the fetched instruction, its PC and the PC+8 link address each cycle.
- Holds its contents on a hazard stall and drives the matching PC-freeze request back to fetch.
- Inserts a bubble on flush, flags misaligned fetch PCs, and keeps saturating stall/flush/issue performance counters.

Parameters:
RESET_PC, 32'h0000_3000, value loaded into D_PC on reset; equals the fetch stage's reset PC.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
F_PC  input  32  PC of the instruction currently in fetch.
F_instr  input  32  instruction word read at F_PC.
stall  input  1  hazard-unit stall request; decode must hold.
flush  input  1  request to replace the decode-stage instruction with a bubble.
freezePC  output  1  PC hold request to the fetch stage.
D_PC  output  32  PC of the instruction in decode.
D_PC8  output  32  D_PC+8; link value for jal/jalr.
D_instr  output  32  instruction in decode; 32'h0 (sll nop) for a bubble.
D_valid  output  1  1 = D_instr is a real instruction.
D_adel  output  1  1 = the captured F_PC was not word-aligned.
stall_cnt  output  CNT_W  cycles in which stall was applied.
flush_cnt  output  CNT_W  cycles in which a flush was applied.
issue_cnt  output  CNT_W  valid instructions loaded into decode.

Behaviour:
- freezePC = stall, purely combinational. No register sits in this path, so fetch and decode freeze in the same cycle.
- All other outputs are registered. Load latency is 1 cycle: F_* sampled at edge n is visible on D_* after edge n.
- Priority at each rising edge is reset > stall > flush > load.
- Reset (reset==0):
  - D_PC = RESET_PC; D_PC8 = RESET_PC+8; D_instr = 0; D_valid = 0; D_adel = 0.
  - All counters = 0.
  - Reset asserted mid-stall or mid-flush discards everything and still produces these values.
- Stall (reset==1, stall==1):
  - All D_* outputs hold their values.
  - flush is ignored; the requester must keep flush asserted until stall drops.
  - stall_cnt increments.
- Flush (reset==1, stall==0, flush==1):
  - D_instr = 0; D_valid = 0; D_adel = 0.
  - D_PC = F_PC and D_PC8 = F_PC+8, kept for debug traceability.
  - flush_cnt increments.
- Load (reset==1, stall==0, flush==0):
  - D_PC = F_PC; D_PC8 = F_PC+8, computed modulo 2^32 (wraps, no carry out).
  - If F_PC[1:0] != 0: D_instr = 0, D_valid = 0, D_adel = 1. issue_cnt does not change.
  - Otherwise: D_instr = F_instr, D_valid = 1, D_adel = 0. issue_cnt increments.
- Counters:
  - Unsigned and saturating: at all-ones they hold and never wrap.
  - Each counter increments at most once per edge, and only under its own condition above.
- No combinational path from F_* to any D_* output.
- X on F_instr during stall or flush must not propagate to D_instr.

Test Plan:
- Reset then load: hold reset=0 for 2 edges, then release with F_PC=32'h3000, F_instr=32'h3c010001. Required: during reset D_PC=32'h3000, D_valid=0, D_instr=0. After the first released edge: D_PC=32'h3000, D_PC8=32'h3008, D_instr=32'h3c010001, D_valid=1, issue_cnt=1.
- Stall hold: after loading 32'h3004/32'h34210002, apply stall=1 for 3 edges while F_PC changes to 32'h3008. Required: freezePC=1 in the same cycle as stall; D_PC stays 32'h3004; stall_cnt=3; the next unstalled edge loads 32'h3008.
- Flush and stall+flush: flush=1 with F_PC=32'h300c gives D_instr=0, D_valid=0, D_PC=32'h300c, flush_cnt=1. With stall=1 and flush=1 together, D_* hold and flush_cnt is unchanged.
- Misaligned PC: F_PC=32'h3002 gives D_adel=1, D_valid=0, D_instr=0, issue_cnt unchanged. The next aligned load clears D_adel.
- Wrap and saturation: F_PC=32'hfffffffc gives D_PC8=32'h00000004. Hold stall for 2^CNT_W+5 cycles: stall_cnt stays at 16'hffff.
- Reset mid-stall: with stall=1 and D_PC=32'h3010, assert reset=0 for 1 edge. Required: D_PC=32'h3000, D_valid=0, all counters 0; freezePC still follows stall.
